cache_refill: RTL and testbench
===============================

// Module: cache_refill
// PURPOSE
//  Miss-handling FSM that sits directly upstream of the cache data array. It
//  drives the array's block/word index, write data and byte enables.
//  On a miss it first writes back the victim block to memory if dirty, then
//  refills the block word by word from memory, then pulses done.
//  Memory side is a single-word req/ack handshake.
// PARAMETERS
//  BLKIDX_BIT  4  block index width (BLK_NUM = 1<<BLKIDX_BIT)
//  WRDIDX_BIT  4  word-in-block index width (WRD_NUM = 1<<WRDIDX_BIT)
//  localparam TAG_BIT = 32-BLKIDX_BIT-WRDIDX_BIT-2
// PORTS
//  clk          in   1           single clock, all state on rising edge
//  rst          in   1           synchronous, active-high reset
//  miss_valid   in   1           miss request present
//  miss_ready   out  1           FSM idle, request accepted when valid&ready
//  miss_blkidx  in   BLKIDX_BIT  block index of the miss
//  miss_tag     in   TAG_BIT     tag of the requested line
//  miss_dirty   in   1           victim block is dirty
//  victim_tag   in   TAG_BIT     tag of the victim (used only if dirty)
//  done         out  1           one-cycle pulse when refill complete
//  cd_blkidx    out  BLKIDX_BIT  to data array: block index
//  cd_wrdidx    out  WRDIDX_BIT  to data array: word index
//  cd_wdata     out  32          to data array: write data
//  cd_wen       out  4           to data array: byte write enables
//  cd_rdata     in   32          from data array: combinational read of cd_blkidx/cd_wrdidx
//  mem_req      out  1           memory word request, held until mem_ack
//  mem_we       out  1           1 = write (writeback), 0 = read (refill)
//  mem_addr     out  32          byte address {tag,blkidx,wrdidx,2'b00}
//  mem_wdata    out  32          writeback data
//  mem_ack      in   1           one-cycle word completion; mem_rdata valid with it on reads
//  mem_rdata    in   32          refill data
// BEHAVIOUR
//  States: IDLE, WB, RF, DONE. Registers: state, cnt[WRDIDX_BIT-1:0], blk, mtag, vtag.
//  Reset: state=IDLE, cnt=0, blk/tags=0.
//   After reset: miss_ready=1, done=0, mem_req=0, mem_we=0, cd_wen=0, addresses/data 0.
//  IDLE: miss_ready=1. On miss_valid latch blkidx/tags, cnt=0.
//   Next state WB if miss_dirty else RF. mem_ack ignored in IDLE and DONE.
//  WB: mem_req=1, mem_we=1, mem_addr={vtag,blk,cnt,2'b00}.
//   cd_wrdidx=cnt; mem_wdata=cd_rdata (same cycle, combinational path).
//   On mem_ack: cnt+1. Ack at cnt==WRD_NUM-1: cnt wraps to 0, go to RF.
//  RF: mem_req=1, mem_we=0, mem_addr={mtag,blk,cnt,2'b00}.
//   cd_wrdidx=cnt; cd_wdata=mem_rdata; cd_wen=4'hF only in the mem_ack cycle, else 0.
//   On mem_ack: cnt+1. Ack at cnt==WRD_NUM-1: go to DONE.
//  DONE: done=1 for exactly one cycle, mem_req=0, then IDLE.
//   Earliest next accept is the cycle after done.
//  cd_blkidx=blk in WB/RF/DONE, else miss_blkidx. cd_wen=0 in every state except RF.
//  mem_req stays high across consecutive acks. Address advances the cycle after each ack.
//   Back-to-back acks sustain 1 word/cycle.
//  Latency with zero-wait memory:
//   clean miss = 1 accept + WRD_NUM + 1 DONE cycles;
//   dirty miss adds WRD_NUM cycles.
//  Reset mid-operation: next cycle state=IDLE, mem_req=0, cd_wen=0.
//   Partially refilled words stay in the array; no done pulse.
//  miss_valid while not ready: ignored; requester holds it.
// TESTING
//  Clean miss blk=3 tag=0x1234, mem acks every cycle, rdata=addr ->
//   16 cd_wen=F writes wrdidx 0..15, done at cycle 18.
//  Dirty miss victim_tag=0x55, array preloaded ->
//   16 mem writes addr {0x55,blk,i,00} with array data, then 16 reads, one done pulse.
//  Random 0-3 cycle ack stalls ->
//   mem_req/mem_addr stable while waiting, cd_wen only on ack cycles, final array contents correct.
//  rst asserted at RF cnt=7 ->
//   next cycle IDLE, miss_ready=1, no further cd_wen, no done.
//  Two back-to-back misses (valid held) ->
//   second accepted cycle after done; block indices not mixed.
//  Spurious mem_ack in IDLE ->
//   no state change, cd_wen stays 0.

Source files
------------

// File: rtl/cache_refill_if.sv
// Miss request, cache data-array and memory word-bus signals of the refill FSM.
// master = refill FSM, slave = requester/array/memory side.
interface cache_refill_if #(
  parameter int BLKIDX_BIT = 4,
  parameter int WRDIDX_BIT = 4
);
  localparam int TAG_BIT = 32 - BLKIDX_BIT - WRDIDX_BIT - 2;

  logic                  miss_valid;
  logic                  miss_ready;
  logic [BLKIDX_BIT-1:0] miss_blkidx;
  logic [TAG_BIT-1:0]    miss_tag;
  logic                  miss_dirty;
  logic [TAG_BIT-1:0]    victim_tag;
  logic                  done;

  logic [BLKIDX_BIT-1:0] cd_blkidx;
  logic [WRDIDX_BIT-1:0] cd_wrdidx;
  logic [31:0]           cd_wdata;
  logic [3:0]            cd_wen;
  logic [31:0]           cd_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (
    input  miss_valid, miss_blkidx, miss_tag, miss_dirty, victim_tag,
    input  cd_rdata, mem_ack, mem_rdata,
    output miss_ready, done, cd_blkidx, cd_wrdidx, cd_wdata, cd_wen,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output miss_valid, miss_blkidx, miss_tag, miss_dirty, victim_tag,
    output cd_rdata, mem_ack, mem_rdata,
    input  miss_ready, done, cd_blkidx, cd_wrdidx, cd_wdata, cd_wen,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_refill.sv
// Cache miss handler: optional dirty-victim writeback, word-by-word refill
// into the data array, then a one-cycle done pulse.
module cache_refill #(
  parameter int BLKIDX_BIT = 4,
  parameter int WRDIDX_BIT = 4
) (
  input logic           clk,
  input logic           rst,
  cache_refill_if.master bus
);
  localparam int TAG_BIT = 32 - BLKIDX_BIT - WRDIDX_BIT - 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] RF   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [WRDIDX_BIT-1:0] cnt_q,   cnt_d;
  logic [BLKIDX_BIT-1:0] blk_q,   blk_d;
  logic [TAG_BIT-1:0]    mtag_q,  mtag_d;
  logic [TAG_BIT-1:0]    vtag_q,  vtag_d;
  logic                  last_wrd;

  assign last_wrd = &cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    mtag_d  = mtag_q;
    vtag_d  = vtag_q;
    case (state_q)
      IDLE: begin
        if (bus.miss_valid) begin
          blk_d   = bus.miss_blkidx;
          mtag_d  = bus.miss_tag;
          vtag_d  = bus.victim_tag;
          cnt_d   = '0;
          state_d = bus.miss_dirty ? WB : RF;
        end
      end
      WB: begin
        // counter wraps to 0 on the last writeback ack, ready for the refill
        if (bus.mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (last_wrd) state_d = RF;
        end
      end
      RF: begin
        if (bus.mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (last_wrd) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      mtag_q  <= '0;
      vtag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      mtag_q  <= mtag_d;
      vtag_q  <= vtag_d;
    end
  end

  logic in_wb, in_rf;
  assign in_wb = (state_q == WB);
  assign in_rf = (state_q == RF);

  assign bus.miss_ready = (state_q == IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.mem_req    = in_wb | in_rf;
  assign bus.mem_we     = in_wb;

  // idle presents the incoming index so the array is already looking at it
  assign bus.cd_blkidx  = (state_q == IDLE) ? bus.miss_blkidx : blk_q;
  assign bus.cd_wrdidx  = cnt_q;

  // writeback data is the array's combinational read of the current word
  assign bus.mem_wdata  = in_wb ? bus.cd_rdata  : 32'h0;
  assign bus.cd_wdata   = in_rf ? bus.mem_rdata : 32'h0;
  assign bus.cd_wen     = (in_rf && bus.mem_ack) ? 4'hF : 4'h0;

  always_comb begin
    bus.mem_addr = 32'h0;
    if (in_wb)      bus.mem_addr = {vtag_q, blk_q, cnt_q, 2'b00};
    else if (in_rf) bus.mem_addr = {mtag_q, blk_q, cnt_q, 2'b00};
  end
endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: vector table of misses plus hand-written
// reset, back-to-back and spurious-ack sequences against a memory/array model.
module tb_cache_refill;
  localparam logic [31:0] K = 32'h5A5A_5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_refill_if #(.BLKIDX_BIT(4), .WRDIDX_BIT(4)) bus();
  cache_refill #(.BLKIDX_BIT(4), .WRDIDX_BIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [21:0] t, input logic [3:0] b, input logic [3:0] w);
    return {t, b, w, 2'b00} ^ K;
  endfunction

  // data array model
  logic [31:0] arr [16][16];
  bit          pl_en = 1'b0;
  logic [3:0]  pl_blk = '0;
  logic [31:0] pl_base = '0;
  int          wen_cnt = 0;
  int          done_cnt = 0;

  assign bus.cd_rdata = arr[bus.cd_blkidx][bus.cd_wrdidx];

  always @(posedge clk) begin
    if (pl_en) begin
      for (int w = 0; w < 16; w++) arr[pl_blk][w] <= pl_base + 32'(w);
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.cd_wen[b]) arr[bus.cd_blkidx][bus.cd_wrdidx][8*b +: 8] <= bus.cd_wdata[8*b +: 8];
    end
    if (bus.cd_wen != 4'h0) wen_cnt <= wen_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  // memory responder: random 0..stall_max wait per word, logs every word
  bit          spur = 1'b0;
  int          stall_max = 0;
  bit          loaded = 1'b0;
  int          wcnt = 0;
  logic [31:0] held_addr;
  logic        held_we;
  logic [31:0] wq_addr[$], wq_data[$], rq_addr[$];

  always @(posedge clk) begin
    #1;
    if (spur) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
    end else if (rst || !bus.mem_req) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'h0;
      loaded        = 1'b0;
    end else begin
      if (loaded) begin
        chk("addr_stable", bus.mem_addr, held_addr);
        chk("we_stable", 32'(bus.mem_we), 32'(held_we));
      end else begin
        loaded    = 1'b1;
        held_addr = bus.mem_addr;
        held_we   = bus.mem_we;
        wcnt      = $urandom_range(stall_max, 0);
      end
      if (wcnt == 0) begin
        bus.mem_ack = 1'b1;
        loaded      = 1'b0;
        if (bus.mem_we) begin
          wq_addr.push_back(bus.mem_addr);
          wq_data.push_back(bus.mem_wdata);
          bus.mem_rdata = 32'h0;
        end else begin
          rq_addr.push_back(bus.mem_addr);
          bus.mem_rdata = bus.mem_addr ^ K;
        end
      end else begin
        bus.mem_ack = 1'b0;
        wcnt--;
      end
    end
  end

  // byte enables may only fire on a read-ack cycle
  always @(negedge clk) begin
    if (!rst)
      chk("wen_on_ack", 32'(bus.cd_wen),
          (bus.mem_ack && bus.mem_req && !bus.mem_we) ? 32'hF : 32'h0);
  end

  task automatic preload(input logic [3:0] b, input logic [31:0] base);
    @(negedge clk);
    pl_blk = b; pl_base = base; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_miss(input logic [3:0] b, input logic [21:0] t, input logic d,
                         input logic [21:0] vt, output int cyc);
    int n;
    wq_addr.delete(); wq_data.delete(); rq_addr.delete();
    @(negedge clk);
    bus.miss_valid = 1'b1; bus.miss_blkidx = b; bus.miss_tag = t;
    bus.miss_dirty = d;    bus.victim_tag  = vt;
    n = 0;
    while (!bus.miss_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_seen", 32'(bus.miss_ready), 32'h1);
    @(posedge clk); #2 bus.miss_valid = 1'b0;
    cyc = 1;
    do begin @(negedge clk); cyc++; end while (!bus.done && cyc < 2000);
    chk("done_seen", 32'(bus.done), 32'h1);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'h0);
    chk("ready_after_done", 32'(bus.miss_ready), 32'h1);
  endtask

  typedef struct {
    logic [3:0]  blk;
    logic [21:0] tag;
    logic        dirty;
    logic [21:0] vtag;
    int          stall;
    int          exp_cyc;   // 0 = not checked (random stalls)
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          cyc, n, wc, dc;
    logic [31:0] base;
    logic [3:0]  iw;

    vecs[0] = '{4'd3,  22'h001234, 1'b0, 22'h000000, 0, 18};
    vecs[1] = '{4'd9,  22'h00ABCD, 1'b1, 22'h000055, 0, 34};
    vecs[2] = '{4'd0,  22'h3FFFFF, 1'b1, 22'h000000, 0, 34};
    vecs[3] = '{4'd15, 22'h000000, 1'b0, 22'h3FFFFF, 0, 18};
    vecs[4] = '{4'd3,  22'h002222, 1'b1, 22'h001234, 3, 0};
    vecs[5] = '{4'd6,  22'h000155, 1'b0, 22'h000000, 3, 0};

    bus.miss_valid = 1'b0; bus.miss_blkidx = '0; bus.miss_tag = '0;
    bus.miss_dirty = 1'b0; bus.victim_tag  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready",  32'(bus.miss_ready), 32'h1);
    chk("rst_done",   32'(bus.done),       32'h0);
    chk("rst_req",    32'(bus.mem_req),    32'h0);
    chk("rst_we",     32'(bus.mem_we),     32'h0);
    chk("rst_wen",    32'(bus.cd_wen),     32'h0);
    chk("rst_addr",   bus.mem_addr,        32'h0);
    chk("rst_wrdidx", 32'(bus.cd_wrdidx),  32'h0);
    chk("rst_mwdata", bus.mem_wdata,       32'h0);
    chk("rst_cwdata", bus.cd_wdata,        32'h0);

    for (int b = 0; b < 16; b++) preload(4'(b), 32'hA000_0000 + 32'(b << 8));

    // spurious acks while idle
    spur = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spur_ready", 32'(bus.miss_ready), 32'h1);
      chk("spur_req",   32'(bus.mem_req),    32'h0);
      chk("spur_wen",   32'(bus.cd_wen),     32'h0);
    end
    spur = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      base = 32'hC000_0000 + 32'(v << 16) + 32'(vecs[v].blk) * 32'h100;
      preload(vecs[v].blk, base);
      stall_max = vecs[v].stall;
      do_miss(vecs[v].blk, vecs[v].tag, vecs[v].dirty, vecs[v].vtag, cyc);
      if (vecs[v].exp_cyc != 0) chk("latency", 32'(cyc), 32'(vecs[v].exp_cyc));
      chk("n_wb",   32'(wq_addr.size()), vecs[v].dirty ? 32'd16 : 32'd0);
      chk("n_rf",   32'(rq_addr.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
        iw = 4'(i);
        if (vecs[v].dirty && i < wq_addr.size()) begin
          chk("wb_addr", wq_addr[i], {vecs[v].vtag, vecs[v].blk, iw, 2'b00});
          chk("wb_data", wq_data[i], base + 32'(i));
        end
        if (i < rq_addr.size())
          chk("rf_addr", rq_addr[i], {vecs[v].tag, vecs[v].blk, iw, 2'b00});
        chk("array", arr[vecs[v].blk][i], rd_of(vecs[v].tag, vecs[v].blk, iw));
      end
    end
    stall_max = 0;

    // reset in the middle of the refill at word 7
    preload(4'd5, 32'hB000_0500);
    @(negedge clk);
    bus.miss_valid = 1'b1; bus.miss_blkidx = 4'd5; bus.miss_tag = 22'h77; bus.miss_dirty = 1'b0;
    @(posedge clk); #2 bus.miss_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(bus.mem_req && !bus.mem_we && bus.mem_addr[5:2] == 4'd7) && n < 100) begin
      @(negedge clk); n++;
    end
    chk("reached_rf7", 32'(bus.mem_addr[5:2]), 32'h7);
    dc = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.miss_ready), 32'h1);
    chk("mid_rst_req",   32'(bus.mem_req),    32'h0);
    chk("mid_rst_wen",   32'(bus.cd_wen),     32'h0);
    chk("mid_rst_done",  32'(bus.done),       32'h0);
    rst = 1'b0;
    wc = wen_cnt;
    repeat (6) @(negedge clk);
    chk("no_wen_after_rst",  32'(wen_cnt),  32'(wc));
    chk("no_done_after_rst", 32'(done_cnt), 32'(dc));
    chk("idle_after_rst",    32'(bus.miss_ready), 32'h1);
    chk("partial_kept",   arr[5][3],  rd_of(22'h77, 4'd5, 4'd3));
    chk("untouched_word", arr[5][12], 32'hB000_050C);

    // two misses with valid held across the first
    preload(4'd7, 32'hE000_0700);
    preload(4'd8, 32'hE000_0800);
    wq_addr.delete(); wq_data.delete(); rq_addr.delete();
    dc = done_cnt;
    @(negedge clk);
    bus.miss_valid = 1'b1; bus.miss_blkidx = 4'd7; bus.miss_tag = 22'h701;
    bus.miss_dirty = 1'b1; bus.victim_tag  = 22'h3;
    @(posedge clk); #2;
    bus.miss_blkidx = 4'd8; bus.miss_tag = 22'h802; bus.miss_dirty = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 200);
    chk("b2b_done1",       32'(bus.done),       32'h1);
    chk("b2b_busy_in_done", 32'(bus.miss_ready), 32'h0);
    @(negedge clk);
    chk("b2b_ready_next",  32'(bus.miss_ready), 32'h1);
    @(posedge clk); #2 bus.miss_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 200);
    chk("b2b_done2",    32'(bus.done), 32'h1);
    chk("b2b_latency2", 32'(n + 1),    32'd18);
    @(negedge clk);
    chk("b2b_done_cnt", 32'(done_cnt - dc), 32'd2);
    chk("b2b_wb_n",     32'(wq_addr.size()), 32'd16);
    if (wq_data.size() > 15) chk("b2b_wb_data15", wq_data[15], 32'hE000_070F);
    chk("b2b_blk7_w0",  arr[7][0],  rd_of(22'h701, 4'd7, 4'd0));
    chk("b2b_blk7_w15", arr[7][15], rd_of(22'h701, 4'd7, 4'd15));
    chk("b2b_blk8_w0",  arr[8][0],  rd_of(22'h802, 4'd8, 4'd0));
    chk("b2b_blk8_w15", arr[8][15], rd_of(22'h802, 4'd8, 4'd15));

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
